// File: rtl/bin_load_sequencer_if.sv
// Core-side bundle between the bin load sequencer and one sat_engine.
// master = sequencer (drives load/start/read strobes), slave = core.
interface bin_load_sequencer_if #(
  parameter int NUM_CLAUSES      = 8,
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 16
);
  logic                                 core_start_o;
  logic [WIDTH_LVL-1:0]                 core_cur_bin_num_o;
  logic [WIDTH_LVL-1:0]                 core_load_lvl_o;
  logic                                 core_base_lvl_en_o;
  logic [WIDTH_LVL-1:0]                 core_base_lvl_o;
  logic [NUM_CLAUSES-1:0]               core_wr_carray_o;
  logic [2*NUM_VARS-1:0]                core_clause_o;
  logic [NUM_VARS-1:0]                  core_wr_var_states_o;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] core_var_states_o;
  logic [NUM_LVLS-1:0]                  core_wr_lvl_states_o;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] core_lvl_states_o;
  logic [NUM_CLAUSES-1:0]               core_rd_carray_o;

  logic                                 core_done_i;
  logic                                 core_sat_i;
  logic                                 core_unsat_i;
  logic [WIDTH_LVL-1:0]                 core_cur_lvl_i;
  logic [WIDTH_LVL-1:0]                 core_bkt_lvl_i;
  logic [2*NUM_VARS-1:0]                core_clause_i;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] core_var_states_i;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] core_lvl_states_i;

  modport master (
    output core_start_o, core_cur_bin_num_o, core_load_lvl_o,
    output core_base_lvl_en_o, core_base_lvl_o,
    output core_wr_carray_o, core_clause_o,
    output core_wr_var_states_o, core_var_states_o,
    output core_wr_lvl_states_o, core_lvl_states_o,
    output core_rd_carray_o,
    input  core_done_i, core_sat_i, core_unsat_i,
    input  core_cur_lvl_i, core_bkt_lvl_i, core_clause_i,
    input  core_var_states_i, core_lvl_states_i
  );

  modport slave (
    input  core_start_o, core_cur_bin_num_o, core_load_lvl_o,
    input  core_base_lvl_en_o, core_base_lvl_o,
    input  core_wr_carray_o, core_clause_o,
    input  core_wr_var_states_o, core_var_states_o,
    input  core_wr_lvl_states_o, core_lvl_states_o,
    input  core_rd_carray_o,
    output core_done_i, core_sat_i, core_unsat_i,
    output core_cur_lvl_i, core_bkt_lvl_i, core_clause_i,
    output core_var_states_i, core_lvl_states_i
  );
endinterface

// File: rtl/bin_load_sequencer.sv
// Drives one sat_engine through a full bin pass: load clauses and
// states, start, wait for done, read clauses back, capture states.
module bin_load_sequencer #(
  parameter int NUM_CLAUSES      = 8,
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 16,
  parameter int WIDTH_CYC        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [WIDTH_LVL-1:0]                 cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
  input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 sat_o,
  output logic                                 unsat_o,
  output logic [WIDTH_LVL-1:0]                 cur_lvl_o,
  output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
  output logic [WIDTH_CYC-1:0]                 run_cycles_o,
  output logic                                 cl_req_o,
  output logic [$clog2(NUM_CLAUSES)-1:0]       cl_idx_o,
  input  logic                                 cl_valid_i,
  input  logic [2*NUM_VARS-1:0]                cl_data_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vs_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] ls_i,
  output logic                                 wb_valid_o,
  input  logic                                 wb_ready_i,
  output logic [$clog2(NUM_CLAUSES)-1:0]       wb_idx_o,
  output logic [2*NUM_VARS-1:0]                wb_data_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vs_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] ls_o,
  bin_load_sequencer_if.master                 core
);
  localparam int IW = $clog2(NUM_CLAUSES);
  localparam logic [IW-1:0] LAST = IW'(NUM_CLAUSES - 1);
  localparam logic [NUM_CLAUSES-1:0] ONE = NUM_CLAUSES'(1);

  // RDW covers the core's one-cycle clause read latency
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WRC, S_LDVS, S_LDLS, S_START,
    S_RUN, S_RDC, S_RDW, S_WB, S_CAPS, S_DONE
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;

  assign w_idx_nxt = r_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state                   <= S_IDLE;
      r_idx                     <= '0;
      busy_o                    <= 1'b0;
      done_o                    <= 1'b0;
      sat_o                     <= 1'b0;
      unsat_o                   <= 1'b0;
      cur_lvl_o                 <= '0;
      bkt_lvl_o                 <= '0;
      run_cycles_o              <= '0;
      cl_req_o                  <= 1'b0;
      cl_idx_o                  <= '0;
      wb_valid_o                <= 1'b0;
      wb_idx_o                  <= '0;
      wb_data_o                 <= '0;
      vs_o                      <= '0;
      ls_o                      <= '0;
      core.core_start_o         <= 1'b0;
      core.core_cur_bin_num_o   <= '0;
      core.core_load_lvl_o      <= '0;
      core.core_base_lvl_en_o   <= 1'b0;
      core.core_base_lvl_o      <= '0;
      core.core_wr_carray_o     <= '0;
      core.core_clause_o        <= '0;
      core.core_wr_var_states_o <= '0;
      core.core_var_states_o    <= '0;
      core.core_wr_lvl_states_o <= '0;
      core.core_lvl_states_o    <= '0;
      core.core_rd_carray_o     <= '0;
    end else begin
      done_o                    <= 1'b0;
      core.core_start_o         <= 1'b0;
      core.core_base_lvl_en_o   <= 1'b0;
      core.core_wr_carray_o     <= '0;
      core.core_wr_var_states_o <= '0;
      core.core_wr_lvl_states_o <= '0;
      core.core_rd_carray_o     <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            core.core_cur_bin_num_o <= cur_bin_num_i;
            core.core_load_lvl_o    <= load_lvl_i;
            core.core_base_lvl_o    <= base_lvl_i;
            r_idx        <= '0;
            cl_idx_o     <= '0;
            cl_req_o     <= 1'b1;
            run_cycles_o <= '0;
            busy_o       <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (cl_valid_i) begin
            cl_req_o              <= 1'b0;
            core.core_clause_o    <= cl_data_i;
            core.core_wr_carray_o <= ONE << r_idx;
            r_state               <= S_WRC;
          end
        end
        S_WRC: begin
          if (r_idx == LAST) begin
            r_idx                     <= '0;
            core.core_wr_var_states_o <= '1;
            core.core_var_states_o    <= vs_i;
            r_state                   <= S_LDVS;
          end else begin
            r_idx    <= w_idx_nxt;
            cl_idx_o <= w_idx_nxt;
            cl_req_o <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_LDVS: begin
          core.core_wr_lvl_states_o <= '1;
          core.core_lvl_states_o    <= ls_i;
          r_state                   <= S_LDLS;
        end
        S_LDLS: begin
          core.core_start_o       <= 1'b1;
          core.core_base_lvl_en_o <= 1'b1;
          r_state                 <= S_START;
        end
        S_START: r_state <= S_RUN;
        S_RUN: begin
          if (run_cycles_o != '1)
            run_cycles_o <= run_cycles_o + WIDTH_CYC'(1);
          if (core.core_done_i) begin
            sat_o                 <= core.core_sat_i;
            unsat_o               <= core.core_unsat_i;
            cur_lvl_o             <= core.core_cur_lvl_i;
            bkt_lvl_o             <= core.core_bkt_lvl_i;
            r_idx                 <= '0;
            core.core_rd_carray_o <= ONE;
            r_state               <= S_RDC;
          end
        end
        S_RDC: r_state <= S_RDW;
        S_RDW: begin
          wb_data_o  <= core.core_clause_i;
          wb_idx_o   <= r_idx;
          wb_valid_o <= 1'b1;
          r_state    <= S_WB;
        end
        S_WB: begin
          if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
            if (r_idx == LAST) begin
              r_state <= S_CAPS;
            end else begin
              r_idx                 <= w_idx_nxt;
              core.core_rd_carray_o <= ONE << w_idx_nxt;
              r_state               <= S_RDC;
            end
          end
        end
        S_CAPS: begin
          vs_o    <= core.core_var_states_i;
          ls_o    <= core.core_lvl_states_i;
          done_o  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_load_sequencer.sv
// Randomized bench for bin_load_sequencer: a bin-store/core model
// plus per-pass expectations derived from the pass rules.
module tb_bin_load_sequencer;
  localparam int NC  = 8;
  localparam int NV  = 8;
  localparam int NL  = 8;
  localparam int WL  = 16;
  localparam int WVS = 19;
  localparam int WLS = 16;
  localparam int WC  = 16;
  localparam int IW  = $clog2(NC);
  localparam int CW  = 2 * NV;
  localparam int VW  = WVS * NV;
  localparam int LW  = WLS * NL;

  typedef logic [255:0] v_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [WL-1:0] cur_bin_num_i, load_lvl_i, base_lvl_i;
  logic          busy_o, done_o, sat_o, unsat_o;
  logic [WL-1:0] cur_lvl_o, bkt_lvl_o;
  logic [WC-1:0] run_cycles_o;
  logic          cl_req_o;
  logic [IW-1:0] cl_idx_o;
  logic          cl_valid_i;
  logic [CW-1:0] cl_data_i;
  logic [VW-1:0] vs_i, vs_o;
  logic [LW-1:0] ls_i, ls_o;
  logic          wb_valid_o, wb_ready_i;
  logic [IW-1:0] wb_idx_o;
  logic [CW-1:0] wb_data_o;

  always #5 clk = ~clk;

  bin_load_sequencer_if cif ();

  bin_load_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .cur_bin_num_i(cur_bin_num_i),
    .load_lvl_i   (load_lvl_i),
    .base_lvl_i   (base_lvl_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sat_o        (sat_o),
    .unsat_o      (unsat_o),
    .cur_lvl_o    (cur_lvl_o),
    .bkt_lvl_o    (bkt_lvl_o),
    .run_cycles_o (run_cycles_o),
    .cl_req_o     (cl_req_o),
    .cl_idx_o     (cl_idx_o),
    .cl_valid_i   (cl_valid_i),
    .cl_data_i    (cl_data_i),
    .vs_i         (vs_i),
    .ls_i         (ls_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_idx_o     (wb_idx_o),
    .wb_data_o    (wb_data_o),
    .vs_o         (vs_o),
    .ls_o         (ls_o),
    .core         (cif)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [CW-1:0] mem  [NC];
  logic [CW-1:0] carr [NC];
  int            dly  [NC];

  task automatic check(input string tag, input v_t got, input v_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic v_t rnd256();
    v_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One bin pass; this process plays both the bin store and the core.
  task automatic run_pass(input int r_cyc, input int wb_at,
                          input int wb_len, input bit sat,
                          input bit unsat, input logic [WL-1:0] bkt,
                          input bit poke, input bit do_rst);
    logic [CW-1:0] key;
    logic [WL-1:0] cur;
    logic [VW-1:0] cvs;
    logic [LW-1:0] cls;
    int t, exp_t, nwr, nrd, nwb, nvs, nls, fw, cnt, stall, pend;
    bit fin, rd_pend, rst_fired;
    key = CW'($urandom);
    cur = WL'($urandom);
    cvs = VW'(rnd256());
    cls = LW'(rnd256());
    for (int i = 0; i < NC; i++) begin
      mem[i]  = CW'($urandom);
      carr[i] = mem[i] ^ key;
    end
    vs_i          = VW'(rnd256());
    ls_i          = LW'(rnd256());
    cur_bin_num_i = WL'($urandom);
    load_lvl_i    = WL'($urandom);
    base_lvl_i    = WL'($urandom);
    cif.core_var_states_i = cvs;
    cif.core_lvl_states_i = cls;
    exp_t = 5 * NC + 5 + r_cyc + (wb_at >= 0 ? wb_len : 0);
    for (int i = 0; i < NC; i++) exp_t += dly[i];
    nwr = 0; nrd = 0; nwb = 0; nvs = 0; nls = 0;
    fw = 0; cnt = 0; stall = 0; pend = 0;
    fin = 0; rd_pend = 0; rst_fired = 0;
    t = 0;
    start_i = 1'b1;
    while (!fin && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
      rst              = 1'b1;
      start_i          = 1'b0;
      cif.core_done_i  = 1'b0;
      cif.core_sat_i   = ~sat;
      cif.core_unsat_i = ~unsat;
      cif.core_cur_lvl_i = ~cur;
      cif.core_bkt_lvl_i = ~bkt;
      if (rst_fired) begin
        check("rst_busy", v_t'(busy_o), v_t'(0));
        check("rst_strobes",
              v_t'({cif.core_start_o, cif.core_base_lvl_en_o,
                    cif.core_wr_carray_o, cif.core_wr_var_states_o,
                    cif.core_wr_lvl_states_o, cif.core_rd_carray_o,
                    cl_req_o, wb_valid_o, done_o}), v_t'(0));
        cl_valid_i = 1'b0;
        wb_ready_i = 1'b0;
        return;
      end
      cif.core_clause_i = rd_pend ? carr[pend] : CW'($urandom);
      rd_pend = 0;
      if (cl_req_o) begin
        fw++;
        if (fw == 1) check("cl_idx", v_t'(cl_idx_o), v_t'(nwr));
        if (fw == dly[nwr] + 1) begin
          cl_valid_i = 1'b1;
          cl_data_i  = mem[nwr];
        end else begin
          cl_valid_i = 1'b0;
          cl_data_i  = CW'($urandom);
        end
      end else begin
        fw = 0;
        cl_valid_i = 1'b0;
      end
      if (cif.core_wr_carray_o != '0) begin
        check("wr_onehot", v_t'(cif.core_wr_carray_o), v_t'(1 << nwr));
        check("wr_data", v_t'(cif.core_clause_o), v_t'(mem[nwr]));
        nwr++;
      end
      if (cif.core_wr_var_states_o != '0) begin
        check("vs_after_clauses", v_t'(nwr), v_t'(NC));
        check("wr_vs", v_t'(cif.core_wr_var_states_o), v_t'({NV{1'b1}}));
        check("vs_data", v_t'(cif.core_var_states_o), v_t'(vs_i));
        nvs++;
        if (poke) cif.core_done_i = 1'b1;
      end
      if (cif.core_wr_lvl_states_o != '0) begin
        check("ls_after_vs", v_t'(nvs), v_t'(1));
        check("wr_ls", v_t'(cif.core_wr_lvl_states_o), v_t'({NL{1'b1}}));
        check("ls_data", v_t'(cif.core_lvl_states_o), v_t'(ls_i));
        nls++;
      end
      if (cif.core_start_o) begin
        check("start_after_ls", v_t'(nls), v_t'(1));
        check("start_lvls",
              v_t'({cif.core_base_lvl_en_o, cif.core_cur_bin_num_o,
                    cif.core_load_lvl_o, cif.core_base_lvl_o}),
              v_t'({1'b1, cur_bin_num_i, load_lvl_i, base_lvl_i}));
        cnt = r_cyc;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          cif.core_done_i    = 1'b1;
          cif.core_sat_i     = sat;
          cif.core_unsat_i   = unsat;
          cif.core_cur_lvl_i = cur;
          cif.core_bkt_lvl_i = bkt;
        end else if (cnt == r_cyc / 2) begin
          if (poke) start_i = 1'b1;
          if (do_rst) begin
            rst = 1'b0;
            rst_fired = 1;
          end
        end
      end
      if (cif.core_rd_carray_o != '0) begin
        check("rd_onehot", v_t'(cif.core_rd_carray_o), v_t'(1 << nrd));
        rd_pend = 1;
        pend = nrd;
        nrd++;
      end
      if (wb_valid_o) begin
        check("rd_in_wb", v_t'(cif.core_rd_carray_o), v_t'(0));
        check("wb_idx", v_t'(wb_idx_o), v_t'(nwb));
        check("wb_data", v_t'(wb_data_o), v_t'(carr[nwb]));
        if (nwb == wb_at && stall < wb_len) begin
          wb_ready_i = 1'b0;
          stall++;
        end else begin
          wb_ready_i = 1'b1;
          nwb++;
        end
      end else begin
        wb_ready_i = 1'($urandom);
      end
      if (done_o) begin
        fin = 1;
        check("pass_len", v_t'(t), v_t'(exp_t));
        check("busy_at_done", v_t'(busy_o), v_t'(1));
        check("wb_count", v_t'(nwb), v_t'(NC));
        check("result",
              v_t'({sat_o, unsat_o, cur_lvl_o, bkt_lvl_o}),
              v_t'({sat, unsat, cur, bkt}));
        check("run_cycles", v_t'(run_cycles_o), v_t'(r_cyc));
        check("vs_o", v_t'(vs_o), v_t'(cvs));
        check("ls_o", v_t'(ls_o), v_t'(cls));
      end
    end
    if (!fin) begin
      check("timeout", v_t'(0), v_t'(1));
      return;
    end
    @(posedge clk);
    #1;
    wb_ready_i = 1'b0;
    check("idle_after", v_t'({busy_o, done_o}), v_t'(0));
    check("hold_result",
          v_t'({sat_o, unsat_o, bkt_lvl_o}), v_t'({sat, unsat, bkt}));
  endtask

  initial begin
    rst           = 1'b0;
    start_i       = 1'b0;
    cl_valid_i    = 1'b0;
    cl_data_i     = '0;
    wb_ready_i    = 1'b0;
    cur_bin_num_i = '0;
    load_lvl_i    = '0;
    base_lvl_i    = '0;
    vs_i          = '0;
    ls_i          = '0;
    cif.core_done_i       = 1'b0;
    cif.core_sat_i        = 1'b0;
    cif.core_unsat_i      = 1'b0;
    cif.core_cur_lvl_i    = '0;
    cif.core_bkt_lvl_i    = '0;
    cif.core_clause_i     = '0;
    cif.core_var_states_i = '0;
    cif.core_lvl_states_i = '0;
    for (int i = 0; i < NC; i++) dly[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl",
          v_t'({busy_o, done_o, cl_req_o, wb_valid_o, sat_o, unsat_o}),
          v_t'(0));
    check("reset_core",
          v_t'({cif.core_start_o, cif.core_base_lvl_en_o,
                cif.core_wr_carray_o, cif.core_wr_var_states_o,
                cif.core_wr_lvl_states_o, cif.core_rd_carray_o}),
          v_t'(0));
    check("reset_fields",
          v_t'({cur_lvl_o, bkt_lvl_o, run_cycles_o}), v_t'(0));
    check("reset_vs", v_t'(vs_o), v_t'(0));
    check("reset_ls", v_t'(ls_o), v_t'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_pass(20, -1, 0, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0);
    dly[3] = 5;
    run_pass(20, -1, 0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    dly[3] = 0;
    run_pass(12, 6, 4, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_pass(15, -1, 0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0);
    run_pass(25, -1, 0, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b0);
    run_pass(30, -1, 0, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b1);
    run_pass(20, -1, 0, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < NC; i++) dly[i] = int'($urandom_range(0, 3));
      run_pass(int'($urandom_range(1, 40)), int'($urandom_range(0, NC - 1)),
               int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               WL'($urandom), 1'b0, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
